// File: rtl/makina_computer.sv
// makina_computer: 16-bit 4-cycle Harvard computer (CPU, register file, instruction ROM, data RAM).
// Define MAKINA_TRACE_EN for a simulation-only tracer printing state at every WB edge.
module makina_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] memory [0:2**ADDR_W-1];

    always_ff @(posedge clk)
        if (i_we) memory[i_addr] <= i_wdata;

    assign o_rdata = memory[i_addr];
endmodule

module makina_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_raddr_a,
    input  logic [2:0]        i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);
    logic [DATA_W-1:0] cpu_registers [0:7];

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            for (int i = 0; i < 8; i++) cpu_registers[i] <= '0;
        else if (i_we && i_waddr != 3'd0)
            cpu_registers[i_waddr] <= i_wdata;

    assign o_rdata_a = (i_raddr_a == 3'd0) ? '0 : cpu_registers[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 3'd0) ? '0 : cpu_registers[i_raddr_b];
endmodule

module makina_cpu #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_instruction,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_fetch,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_halted
);
    typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} stage_t;

    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR = 4'h4,
                           OP_XOR = 4'h5, OP_LD = 4'h7, OP_ST = 4'h8, OP_BEQ = 4'h9,
                           OP_JMP = 4'hA, OP_HALT = 4'hF;

    stage_t            stage;
    logic [ADDR_W-1:0] r_pc, r_next_pc, r_addr;
    logic [DATA_W-1:0] r_a, r_b, r_result;
    logic              r_we, r_halted;

    logic [3:0]        w_op;
    logic [2:0]        w_rd, w_rs, w_rt;
    logic [ADDR_W-1:0] w_off, w_pc_inc, w_next;
    logic [DATA_W-1:0] w_sext9, w_alu, w_rd_a, w_rd_b, w_wdata;
    logic              w_rf_we;

    assign w_op     = i_instruction[15:12];
    assign w_rd     = i_instruction[11:9];
    assign w_rs     = i_instruction[8:6];
    assign w_rt     = i_instruction[5:3];
    assign w_off    = {{(ADDR_W-6){i_instruction[5]}}, i_instruction[5:0]};
    assign w_sext9  = {{(DATA_W-9){i_instruction[8]}}, i_instruction[8:0]};
    assign w_pc_inc = r_pc + ADDR_W'(1);

    assign w_alu = (w_op == OP_ADD) ? r_a + r_b :
                   (w_op == OP_SUB) ? r_a - r_b :
                   (w_op == OP_AND) ? r_a & r_b :
                   (w_op == OP_OR)  ? r_a | r_b :
                   (w_op == OP_XOR) ? r_a ^ r_b : w_sext9;

    assign w_next = (w_op == OP_BEQ)  ? ((r_a == r_b) ? w_pc_inc + w_off : w_pc_inc) :
                    (w_op == OP_JMP)  ? i_instruction[ADDR_W-1:0] :
                    (w_op == OP_HALT) ? r_pc : w_pc_inc;

    // opcodes 1..7 (ALU, LI, LD) are the only register writers
    assign w_rf_we = stage == WB && !r_halted && w_op >= OP_ADD && w_op <= OP_LD;
    assign w_wdata = (w_op == OP_LD) ? i_mem_rdata : r_result;

    makina_regfile #(.DATA_W(DATA_W)) u_RegisterFile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_rf_we),
        .i_waddr   (w_rd),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_rs),
        .i_raddr_b ((w_op == OP_ST || w_op == OP_BEQ) ? w_rd : w_rt),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            stage     <= FETCH;
            r_pc      <= '0;
            r_next_pc <= '0;
            r_addr    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_we      <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (stage)
                FETCH:  stage <= DECODE;
                DECODE: begin
                    r_a   <= w_rd_a;
                    r_b   <= w_rd_b;
                    stage <= EXEC;
                end
                EXEC: begin
                    r_result  <= w_alu;
                    r_addr    <= r_a[ADDR_W-1:0] + w_off;
                    r_next_pc <= w_next;
                    r_we      <= w_op == OP_ST && !r_halted;
                    stage     <= WB;
                end
                WB: begin
                    r_we  <= 1'b0;
                    stage <= FETCH;
                    if (!r_halted) begin
                        r_pc <= r_next_pc;
                        if (w_op == OP_HALT) r_halted <= 1'b1;
                    end
                end
            endcase
        end

    assign o_fetch     = stage == FETCH;
    assign o_pc        = r_pc;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_b;
    assign o_mem_we    = r_we;
    assign o_halted    = r_halted;
endmodule

module makina_computer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic clk,
    input  logic rst,
    output logic halted
);
    logic [ADDR_W-1:0] pc_addr, mem_addr;
    logic [DATA_W-1:0] instruction, cur_memory_data, mem_data_write, w_rom_data;
    logic              mem_write_enabled, w_fetch;

    makina_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ROM (
        .clk     (clk),
        .i_we    (1'b0),
        .i_addr  (pc_addr),
        .i_wdata ('0),
        .o_rdata (w_rom_data)
    );

    makina_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_RAM (
        .clk     (clk),
        .i_we    (mem_write_enabled),
        .i_addr  (mem_addr),
        .i_wdata (mem_data_write),
        .o_rdata (cur_memory_data)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) instruction <= '0;
        else if (w_fetch) instruction <= w_rom_data;

    makina_cpu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_MCPU (
        .clk           (clk),
        .rst           (rst),
        .i_instruction (instruction),
        .i_mem_rdata   (cur_memory_data),
        .o_fetch       (w_fetch),
        .o_pc          (pc_addr),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_data_write),
        .o_mem_we      (mem_write_enabled),
        .o_halted      (halted)
    );

`ifdef MAKINA_TRACE_EN
    always @(posedge clk)
        if (rst && u_MCPU.stage == 2'd3) begin
            if (mem_write_enabled)
                $display("pc=%0d ir=%b r=%h %h %h %h %h %h %h %h ram[%0d]<=%h", pc_addr, instruction,
                         u_MCPU.u_RegisterFile.cpu_registers[0], u_MCPU.u_RegisterFile.cpu_registers[1],
                         u_MCPU.u_RegisterFile.cpu_registers[2], u_MCPU.u_RegisterFile.cpu_registers[3],
                         u_MCPU.u_RegisterFile.cpu_registers[4], u_MCPU.u_RegisterFile.cpu_registers[5],
                         u_MCPU.u_RegisterFile.cpu_registers[6], u_MCPU.u_RegisterFile.cpu_registers[7],
                         mem_addr, mem_data_write);
            else
                $display("pc=%0d ir=%b r=%h %h %h %h %h %h %h %h", pc_addr, instruction,
                         u_MCPU.u_RegisterFile.cpu_registers[0], u_MCPU.u_RegisterFile.cpu_registers[1],
                         u_MCPU.u_RegisterFile.cpu_registers[2], u_MCPU.u_RegisterFile.cpu_registers[3],
                         u_MCPU.u_RegisterFile.cpu_registers[4], u_MCPU.u_RegisterFile.cpu_registers[5],
                         u_MCPU.u_RegisterFile.cpu_registers[6], u_MCPU.u_RegisterFile.cpu_registers[7]);
        end
`endif
endmodule

// File: tb/tb_makina_computer.sv
// tb_makina_computer: directed programs loaded into ROM/RAM, checking registers, RAM, PC and stage.
module tb_makina_computer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;
    int   errors = 0;
    int   checks = 0;

    makina_computer dut (.clk(clk), .rst(rst), .halted(halted));

    always #5 clk = ~clk;

    task automatic start_prog;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.u_ROM.memory[i] = 16'h0000;
    endtask

    task automatic release_rst;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        start_prog;
        @(negedge clk);
        checks++; if (dut.pc_addr !== 8'd0) begin errors++; $display("FAIL reset_pc got=%h exp=00", dut.pc_addr); end
        checks++; if (dut.u_MCPU.stage !== 2'd0) begin errors++; $display("FAIL reset_stage got=%0d exp=0", dut.u_MCPU.stage); end
        checks++; if (dut.instruction !== 16'h0000) begin errors++; $display("FAIL reset_ir got=%h exp=0000", dut.instruction); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (dut.mem_write_enabled !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", dut.mem_write_enabled); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.u_MCPU.u_RegisterFile.cpu_registers[i] !== 16'h0000) begin
                errors++; $display("FAIL reset_r%0d got=%h exp=0000", i, dut.u_MCPU.u_RegisterFile.cpu_registers[i]);
            end
        end
    endtask

    task automatic test_sum;
        start_prog;
        dut.u_ROM.memory[0] = 16'h7200;
        dut.u_ROM.memory[1] = 16'h7401;
        dut.u_ROM.memory[2] = 16'h1650;
        dut.u_ROM.memory[3] = 16'h8602;
        dut.u_ROM.memory[4] = 16'hF000;
        dut.u_RAM.memory[0] = 16'd5;
        dut.u_RAM.memory[1] = 16'd3;
        dut.u_RAM.memory[2] = 16'd0;
        release_rst;
        run(19);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL sum_halt_early got=%b exp=0", halted); end
        checks++; if (dut.u_RAM.memory[2] !== 16'd8) begin errors++; $display("FAIL sum_ram2_at19 got=%h exp=0008", dut.u_RAM.memory[2]); end
        run(1);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL sum_halted got=%b exp=1", halted); end
        checks++; if (dut.u_RAM.memory[2] !== 16'b0000000000001000) begin errors++; $display("FAIL sum_ram2 got=%h exp=0008", dut.u_RAM.memory[2]); end
        checks++; if (dut.u_RAM.memory[0] !== 16'd5) begin errors++; $display("FAIL sum_ram0 got=%h exp=0005", dut.u_RAM.memory[0]); end
        checks++; if (dut.u_RAM.memory[1] !== 16'd3) begin errors++; $display("FAIL sum_ram1 got=%h exp=0003", dut.u_RAM.memory[1]); end
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[3] !== 16'd8) begin errors++; $display("FAIL sum_r3 got=%h exp=0008", dut.u_MCPU.u_RegisterFile.cpu_registers[3]); end
        checks++; if (dut.pc_addr !== 8'd4) begin errors++; $display("FAIL sum_pc got=%h exp=04", dut.pc_addr); end
        run(8);
        checks++; if (dut.pc_addr !== 8'd4) begin errors++; $display("FAIL halt_pc_hold got=%h exp=04", dut.pc_addr); end
        checks++; if (dut.u_RAM.memory[2] !== 16'd8) begin errors++; $display("FAIL halt_ram_hold got=%h exp=0008", dut.u_RAM.memory[2]); end
    endtask

    task automatic test_alu;
        start_prog;
        dut.u_ROM.memory[0] = 16'h6203;
        dut.u_ROM.memory[1] = 16'h6405;
        dut.u_ROM.memory[2] = 16'h2650;
        dut.u_ROM.memory[3] = 16'h69FF;
        dut.u_ROM.memory[4] = 16'h3A50;
        dut.u_ROM.memory[5] = 16'h4C50;
        dut.u_ROM.memory[6] = 16'h5E50;
        dut.u_ROM.memory[7] = 16'hF000;
        release_rst;
        run(32);
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[1] !== 16'h0003) begin errors++; $display("FAIL li_r1 got=%h exp=0003", dut.u_MCPU.u_RegisterFile.cpu_registers[1]); end
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[2] !== 16'h0005) begin errors++; $display("FAIL li_r2 got=%h exp=0005", dut.u_MCPU.u_RegisterFile.cpu_registers[2]); end
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[3] !== 16'hFFFE) begin errors++; $display("FAIL sub_r3 got=%h exp=fffe", dut.u_MCPU.u_RegisterFile.cpu_registers[3]); end
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[4] !== 16'hFFFF) begin errors++; $display("FAIL li_neg_r4 got=%h exp=ffff", dut.u_MCPU.u_RegisterFile.cpu_registers[4]); end
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[5] !== 16'h0001) begin errors++; $display("FAIL and_r5 got=%h exp=0001", dut.u_MCPU.u_RegisterFile.cpu_registers[5]); end
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[6] !== 16'h0007) begin errors++; $display("FAIL or_r6 got=%h exp=0007", dut.u_MCPU.u_RegisterFile.cpu_registers[6]); end
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[7] !== 16'h0006) begin errors++; $display("FAIL xor_r7 got=%h exp=0006", dut.u_MCPU.u_RegisterFile.cpu_registers[7]); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL alu_halted got=%b exp=1", halted); end
    endtask

    task automatic test_r0;
        start_prog;
        dut.u_ROM.memory[0] = 16'h6007;
        dut.u_ROM.memory[1] = 16'h1200;
        dut.u_ROM.memory[2] = 16'hF000;
        release_rst;
        run(12);
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[0] !== 16'h0000) begin errors++; $display("FAIL r0_store got=%h exp=0000", dut.u_MCPU.u_RegisterFile.cpu_registers[0]); end
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[1] !== 16'h0000) begin errors++; $display("FAIL r0_read got=%h exp=0000", dut.u_MCPU.u_RegisterFile.cpu_registers[1]); end
    endtask

    task automatic test_branch(input logic [15:0] li_r2, input logic [7:0] exp_pc, input logic [15:0] exp_r5, input logic [15:0] exp_r6);
        start_prog;
        dut.u_ROM.memory[0] = 16'h6203;
        dut.u_ROM.memory[1] = li_r2;
        dut.u_ROM.memory[4] = 16'h9282;
        dut.u_ROM.memory[5] = 16'h6A01;
        dut.u_ROM.memory[6] = 16'hF000;
        dut.u_ROM.memory[7] = 16'h6C02;
        dut.u_ROM.memory[8] = 16'hF000;
        release_rst;
        run(20);
        checks++; if (dut.pc_addr !== exp_pc) begin errors++; $display("FAIL beq_pc got=%h exp=%h", dut.pc_addr, exp_pc); end
        run(8);
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[5] !== exp_r5) begin errors++; $display("FAIL beq_r5 got=%h exp=%h", dut.u_MCPU.u_RegisterFile.cpu_registers[5], exp_r5); end
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[6] !== exp_r6) begin errors++; $display("FAIL beq_r6 got=%h exp=%h", dut.u_MCPU.u_RegisterFile.cpu_registers[6], exp_r6); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL beq_halted got=%b exp=1", halted); end
    endtask

    task automatic test_jmp;
        start_prog;
        dut.u_ROM.memory[0]  = 16'hA00A;
        dut.u_ROM.memory[1]  = 16'h6E01;
        dut.u_ROM.memory[10] = 16'h6E09;
        dut.u_ROM.memory[11] = 16'hF000;
        release_rst;
        run(4);
        checks++; if (dut.pc_addr !== 8'd10) begin errors++; $display("FAIL jmp_pc got=%h exp=0a", dut.pc_addr); end
        run(8);
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[7] !== 16'h0009) begin errors++; $display("FAIL jmp_r7 got=%h exp=0009", dut.u_MCPU.u_RegisterFile.cpu_registers[7]); end
        checks++; if (dut.pc_addr !== 8'd11) begin errors++; $display("FAIL jmp_halt_pc got=%h exp=0b", dut.pc_addr); end
    endtask

    task automatic test_addr_wrap;
        start_prog;
        dut.u_ROM.memory[0] = 16'h723F;
        dut.u_ROM.memory[1] = 16'h823E;
        dut.u_ROM.memory[2] = 16'hF000;
        dut.u_RAM.memory[255] = 16'hBEEF;
        dut.u_RAM.memory[254] = 16'h0000;
        release_rst;
        run(12);
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[1] !== 16'hBEEF) begin errors++; $display("FAIL ld_wrap got=%h exp=beef", dut.u_MCPU.u_RegisterFile.cpu_registers[1]); end
        checks++; if (dut.u_RAM.memory[254] !== 16'hBEEF) begin errors++; $display("FAIL st_wrap got=%h exp=beef", dut.u_RAM.memory[254]); end
    endtask

    task automatic test_reset_mid_st;
        start_prog;
        dut.u_ROM.memory[0] = 16'h6255;
        dut.u_ROM.memory[1] = 16'h8204;
        dut.u_ROM.memory[2] = 16'hF000;
        dut.u_RAM.memory[4] = 16'h1234;
        release_rst;
        run(6);
        checks++; if (dut.u_MCPU.stage !== 2'd2) begin errors++; $display("FAIL mid_stage got=%0d exp=2", dut.u_MCPU.stage); end
        checks++; if (dut.instruction !== 16'h8204) begin errors++; $display("FAIL mid_ir got=%h exp=8204", dut.instruction); end
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[1] !== 16'h0055) begin errors++; $display("FAIL mid_r1 got=%h exp=0055", dut.u_MCPU.u_RegisterFile.cpu_registers[1]); end
        rst = 1'b0;
        #1;
        checks++; if (dut.pc_addr !== 8'd0) begin errors++; $display("FAIL abort_pc got=%h exp=00", dut.pc_addr); end
        checks++; if (dut.u_MCPU.stage !== 2'd0) begin errors++; $display("FAIL abort_stage got=%0d exp=0", dut.u_MCPU.stage); end
        checks++; if (dut.u_MCPU.u_RegisterFile.cpu_registers[1] !== 16'h0000) begin errors++; $display("FAIL abort_r1 got=%h exp=0000", dut.u_MCPU.u_RegisterFile.cpu_registers[1]); end
        checks++; if (dut.mem_write_enabled !== 1'b0) begin errors++; $display("FAIL abort_we got=%b exp=0", dut.mem_write_enabled); end
        run(4);
        checks++; if (dut.u_RAM.memory[4] !== 16'h1234) begin errors++; $display("FAIL abort_ram got=%h exp=1234", dut.u_RAM.memory[4]); end
        release_rst;
        run(12);
        checks++; if (dut.u_RAM.memory[4] !== 16'h0055) begin errors++; $display("FAIL restart_ram got=%h exp=0055", dut.u_RAM.memory[4]); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL restart_halted got=%b exp=1", halted); end
    endtask

    task automatic test_stage;
        start_prog;
        release_rst;
        for (int i = 0; i < 9; i++) begin
            checks++; if (dut.u_MCPU.stage !== 2'(i % 4)) begin errors++; $display("FAIL stage_%0d got=%0d exp=%0d", i, dut.u_MCPU.stage, i % 4); end
            checks++; if (dut.pc_addr !== 8'(i / 4)) begin errors++; $display("FAIL stage_pc_%0d got=%0d exp=%0d", i, dut.pc_addr, i / 4); end
            run(1);
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_sum;
        test_alu;
        test_r0;
        test_branch(16'h6403, 8'd7, 16'h0000, 16'h0002);
        test_branch(16'h6404, 8'd5, 16'h0001, 16'h0000);
        test_jmp;
        test_addr_wrap;
        test_reset_mid_st;
        test_stage;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/makina_computer.md
Name: makina_computer

Overview:
- Minimal 16-bit multi-cycle Harvard computer: CPU core, 8-entry register file, instruction ROM and data RAM in one block.
- Top of the simulation hierarchy. Only clock and reset are driven from outside; all activity comes from the ROM program and RAM contents.
- Each instruction takes exactly 4 clock cycles (fetch, decode, execute, writeback).

Parameters:
- ADDR_W, 8, address width of ROM and RAM (depth 2**ADDR_W words each).
- DATA_W, 16, word width of instructions, data and registers (fixed at 16).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset, asynchronous, active-low.
- halted  output  1  high once a HALT instruction has been executed.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst).
- Reset (rst=0) clears:
  - pc_addr=0, stage=FETCH, instruction=0, halted=0.
  - Registers r0..r7=0.
  - mem_write_enabled=0.
- ROM and RAM are not cleared by reset. Their contents are preloaded hierarchically by the bench. Required instance/array names: u_ROM.memory, u_RAM.memory.
- Required internal signals for tracing, all at top level:
  - pc_addr, instruction, mem_addr, cur_memory_data, mem_data_write, mem_write_enabled.
  - u_MCPU.stage and u_MCPU.u_RegisterFile.cpu_registers.
- Stage sequence, 2-bit, wraps FETCH(0) -> DECODE(1) -> EXEC(2) -> WB(3) -> FETCH:
  - FETCH: instruction <= ROM[pc_addr].
  - DECODE: latch operands A=reg[rs], B=reg[rt or rd].
  - EXEC: ALU result and effective address computed; next PC computed.
  - WB: register write or RAM write; pc_addr <= next PC.
- Instruction format: op[15:12], rd[11:9], rs[8:6], rt[5:3], imm6[5:0], imm9[8:0], imm12[11:0]. All immediates are sign-extended except imm12.
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs+rt. 2 SUB rd=rs-rt. 3 AND. 4 OR. 5 XOR.
  - 6 LI rd=sext(imm9).
  - 7 LD rd=RAM[rs+sext(imm6)].
  - 8 ST RAM[rs+sext(imm6)]=rd.
  - 9 BEQ: if rd==rs, PC=PC+1+sext(imm6).
  - A JMP PC=imm12[ADDR_W-1:0].
  - F HALT.
  - B..E execute as NOP.
- Arithmetic is modulo 2**16; no flags.
- Effective address uses the low ADDR_W bits and wraps. PC increment wraps at 2**ADDR_W.
- r0 reads as 0. Writes to r0 are discarded.
- RAM:
  - Combinational read: cur_memory_data=RAM[mem_addr].
  - Synchronous write at the WB rising edge when mem_write_enabled=1.
  - mem_write_enabled is high only during the WB stage of ST.
  - mem_data_write = reg[rd].
- HALT: at WB, halted<=1 and pc_addr holds. Stage keeps cycling but no further register or RAM writes occur until reset.
- Reset mid-instruction aborts it immediately. A partially executed ST never writes unless its WB edge occurred before reset asserted.

Optional Feature:
- MAKINA_TRACE_EN defined: a non-synthesizable tracer prints one line at every WB edge: PC, instruction (binary), r0..r7, and RAM address/data when a write occurs.
- Undefined: no tracer logic and no $display; functional behaviour is identical.

Test Plan:
- Sum program (RAM[0]=5, RAM[1]=3; LD r1,0(r0); LD r2,1(r0); ADD r3,r1,r2; ST r3,2(r0); HALT) -> RAM[2]=0000000000001000 after 20 cycles; halted=1; RAM[0..1] unchanged.
- LI r1,3; LI r2,5; SUB r3,r1,r2 -> r3=16'hFFFE. LI r4,-1 -> r4=16'hFFFF.
- BEQ with r1==r2, imm6=2 at PC 4 -> next PC 7. With operands unequal -> next PC 5. JMP 0x0A -> PC=10.
- LI r0,7 then ADD r1,r0,r0 -> r1=0.
- Assert rst during EXEC of an ST -> pc_addr=0, stage=0, registers 0, target RAM word unchanged; program restarts correctly after release.
- Stage check over 8 consecutive edges -> stage sequence 0,1,2,3,0,1,2,3; pc_addr increments once per 4 cycles.
